hub_port_guard: RTL



---
 rtl/hub_port_guard_pkg.sv | 15 +
 rtl/hub_port_guard_port.sv | 144 ++++++++++++++
 rtl/hub_port_guard.sv | 63 ++++++
 3 files changed

// File: rtl/hub_port_guard_pkg.sv
// rtl/hub_port_guard_pkg.sv - shared state encodings and counter sizing for the hub port guard
package hub_port_guard_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    PART   = 2'd1,
    JABBER = 2'd2
  } port_state_e;

  // A counter that must hold the value v needs this many bits.
  function automatic int cnt_width(input int v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/hub_port_guard_port.sv
// rtl/hub_port_guard_port.sv - single-port jabber/partition FSM and counters (HUB_LONG_COL_EN adds long-collision partition)
module hub_port_guard_port
  import hub_port_guard_pkg::*;
#(
  parameter int JABBER_CYCLES    = 125000,
  parameter int UNJAB_CYCLES     = 24,
  parameter int PARTITION_LIMIT  = 31,
  parameter int RECONNECT_CYCLES = 128,
  parameter int LONG_COL_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_dv,        // raw carrier this cycle
  input  logic dv_d,         // raw carrier of the previous cycle
  input  logic dv_o,         // guarded carrier currently presented to the core
  input  logic jam,
  output logic blocked,
  output logic partitioned,
  output logic jabbering
);

  localparam int RUN_W  = cnt_width(JABBER_CYCLES);
  localparam int IDLE_W = cnt_width(UNJAB_CYCLES);
  localparam int COL_W  = cnt_width(PARTITION_LIMIT);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(JABBER_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(UNJAB_CYCLES);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(PARTITION_LIMIT);

  port_state_e state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [COL_W-1:0]  col_cnt, col_inc, col_nxt;
  logic              col_seen, jam_seen, part_saved, part_nxt;
  logic              event_end, col_eff, jam_eff, jab_trip, reconnect_ok, long_col;

`ifdef HUB_LONG_COL_EN
  localparam int JAM_W = cnt_width(LONG_COL_CYCLES);
  localparam logic [JAM_W-1:0] JAM_MAX = JAM_W'(LONG_COL_CYCLES);
  logic [JAM_W-1:0] jam_cnt, jam_cnt_eff;

  // Count jam cycles that overlap this port's own guarded carrier, saturating.
  always_comb begin
    jam_cnt_eff = jam_cnt;
    if (jam && dv_o && (jam_cnt != JAM_MAX)) begin
      jam_cnt_eff = jam_cnt + JAM_W'(1);
    end
    long_col = (jam_cnt_eff >= JAM_MAX);
  end

  // jam_cnt restarts with every carrier event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jam_cnt <= '0;
    end else if (event_end) begin
      jam_cnt <= '0;
    end else begin
      jam_cnt <= jam_cnt_eff;
    end
  end
`else
  assign long_col = 1'b0;
`endif

  // Counter next values and event qualifiers; the *_eff flags include the current cycle.
  always_comb begin
    run_nxt  = '0;
    idle_nxt = '0;
    if (rx_dv) begin
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    end else begin
      idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
    end
    col_inc      = (col_cnt == COL_MAX) ? col_cnt : col_cnt + COL_W'(1);
    event_end    = dv_d && !rx_dv;
    col_eff      = col_seen || (jam && dv_o);
    jam_eff      = jam_seen || (jam && dv_d);
    jab_trip     = rx_dv && (run_nxt == RUN_MAX);
    reconnect_ok = (32'(run_cnt) >= 32'(RECONNECT_CYCLES)) && !jam_eff;
  end

  // Next-state logic; jabber is checked before event-end handling.
  always_comb begin
    state_nxt = state;
    part_nxt  = part_saved;
    col_nxt   = col_cnt;
    case (state)
      NORMAL: begin
        if (jab_trip) begin
          state_nxt = JABBER;
          part_nxt  = 1'b0;
        end else if (event_end) begin
          col_nxt = col_eff ? col_inc : '0;
          if ((col_eff && (col_inc == COL_MAX)) || long_col) begin
            state_nxt = PART;
          end
        end
      end
      PART: begin
        if (jab_trip) begin
          state_nxt = JABBER;
          part_nxt  = 1'b1;
        end else if (event_end && reconnect_ok) begin
          state_nxt = NORMAL;
          col_nxt   = '0;
        end
      end
      JABBER: begin
        if (idle_nxt == IDLE_MAX) begin
          state_nxt = part_saved ? PART : NORMAL;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // State, counters, per-event flags and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NORMAL;
      part_saved  <= 1'b0;
      run_cnt     <= '0;
      idle_cnt    <= '0;
      col_cnt     <= '0;
      col_seen    <= 1'b0;
      jam_seen    <= 1'b0;
      blocked     <= 1'b0;
      partitioned <= 1'b0;
      jabbering   <= 1'b0;
    end else begin
      state       <= state_nxt;
      part_saved  <= part_nxt;
      run_cnt     <= run_nxt;
      idle_cnt    <= idle_nxt;
      col_cnt     <= col_nxt;
      col_seen    <= event_end ? 1'b0 : col_eff;
      jam_seen    <= event_end ? 1'b0 : jam_eff;
      blocked     <= (state_nxt != NORMAL);
      partitioned <= (state_nxt == PART);
      jabbering   <= (state_nxt == JABBER);
    end
  end

endmodule

// File: rtl/hub_port_guard.sv
// rtl/hub_port_guard.sv - per-port jabber and auto-partition guard on MII receive (HUB_LONG_COL_EN enables long-collision partition)
module hub_port_guard
  import hub_port_guard_pkg::*;
#(
  parameter int PORT_COUNT       = 4,
  parameter int JABBER_CYCLES    = 125000,
  parameter int UNJAB_CYCLES     = 24,
  parameter int PARTITION_LIMIT  = 31,
  parameter int RECONNECT_CYCLES = 128,
  parameter int LONG_COL_CYCLES  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PORT_COUNT-1:0]   rx_dv,
  input  logic [PORT_COUNT-1:0]   rx_er,
  input  logic [4*PORT_COUNT-1:0] rxd,
  input  logic                    jam,
  output logic [PORT_COUNT-1:0]   rx_dv_o,
  output logic [PORT_COUNT-1:0]   rx_er_o,
  output logic [4*PORT_COUNT-1:0] rxd_o,
  output logic [PORT_COUNT-1:0]   partitioned,
  output logic [PORT_COUNT-1:0]   jabbering
);

  logic [PORT_COUNT-1:0] dv_d;
  logic [PORT_COUNT-1:0] blocked;

  // One-cycle input/output stage; the guard mask uses each port's current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_d    <= '0;
      rx_dv_o <= '0;
      rx_er_o <= '0;
      rxd_o   <= '0;
    end else begin
      dv_d    <= rx_dv;
      rx_dv_o <= rx_dv & ~blocked;
      rx_er_o <= rx_er & ~blocked;
      rxd_o   <= rxd;
    end
  end

  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
    hub_port_guard_port #(
      .JABBER_CYCLES   (JABBER_CYCLES),
      .UNJAB_CYCLES    (UNJAB_CYCLES),
      .PARTITION_LIMIT (PARTITION_LIMIT),
      .RECONNECT_CYCLES(RECONNECT_CYCLES),
      .LONG_COL_CYCLES (LONG_COL_CYCLES)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_dv      (rx_dv[i]),
      .dv_d       (dv_d[i]),
      .dv_o       (rx_dv_o[i]),
      .jam        (jam),
      .blocked    (blocked[i]),
      .partitioned(partitioned[i]),
      .jabbering  (jabbering[i])
    );
  end

endmodule
